// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared MIPS opcode/funct codes, FSM state encodings and datapath
//            select codes for the multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_ori   = 6'h0d;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2b;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_lui   = 6'h0f;
    localparam logic [5:0] c_op_jal   = 6'h03;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] c_fn_addu  = 6'h21;
    localparam logic [5:0] c_fn_subu  = 6'h23;
    localparam logic [5:0] c_fn_jr    = 6'h08;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_NOP  = 4'd0,
        I_ADDU = 4'd1,
        I_SUBU = 4'd2,
        I_ORI  = 4'd3,
        I_LW   = 4'd4,
        I_SW   = 4'd5,
        I_BEQ  = 4'd6,
        I_LUI  = 4'd7,
        I_JAL  = 4'd8,
        I_JR   = 4'd9
    } iclass_t;

    localparam logic [1:0] c_rd_rt    = 2'b00;
    localparam logic [1:0] c_rd_rd    = 2'b01;

    localparam logic [1:0] c_m2r_alu  = 2'b00;
    localparam logic [1:0] c_m2r_dm   = 2'b01;
    localparam logic [1:0] c_m2r_lui  = 2'b10;
    localparam logic [1:0] c_m2r_pc   = 2'b11;

    localparam logic [1:0] c_npc_pc4  = 2'b00;
    localparam logic [1:0] c_npc_br   = 2'b01;
    localparam logic [1:0] c_npc_j    = 2'b10;
    localparam logic [1:0] c_npc_rs   = 2'b11;

    localparam logic [1:0] c_alu_add  = 2'b00;
    localparam logic [1:0] c_alu_sub  = 2'b01;
    localparam logic [1:0] c_alu_or   = 2'b10;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] memto_reg;
        logic       ext_op;
        logic [1:0] alu_ctr;
        logic [1:0] npc_sel;
    } sel_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_dec
// Purpose  : Combinational opcode/funct decode into an instruction class and
//            the datapath select bundle. Unknown encodings decode as a nop.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
#(
    parameter logic [1:0] RA_SEL = 2'b10
) (
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output iclass_t    o_iclass,
    output sel_t       o_sel
);

    always_comb begin
        o_iclass = I_NOP;
        o_sel    = '0;
        case (i_opcode)
            c_op_rtype: begin
                case (i_funct)
                    c_fn_addu: begin
                        o_iclass      = I_ADDU;
                        o_sel.reg_dst = c_rd_rd;
                        o_sel.alu_ctr = c_alu_add;
                    end
                    c_fn_subu: begin
                        o_iclass      = I_SUBU;
                        o_sel.reg_dst = c_rd_rd;
                        o_sel.alu_ctr = c_alu_sub;
                    end
                    c_fn_jr: begin
                        o_iclass      = I_JR;
                        o_sel.npc_sel = c_npc_rs;
                    end
                    default: ;
                endcase
            end
            c_op_ori: begin
                o_iclass      = I_ORI;
                o_sel.reg_dst = c_rd_rt;
                o_sel.alu_src = 1'b1;
                o_sel.alu_ctr = c_alu_or;
                o_sel.ext_op  = 1'b1;
            end
            c_op_lw: begin
                o_iclass        = I_LW;
                o_sel.reg_dst   = c_rd_rt;
                o_sel.alu_src   = 1'b1;
                o_sel.memto_reg = c_m2r_dm;
                o_sel.alu_ctr   = c_alu_add;
            end
            c_op_sw: begin
                o_iclass      = I_SW;
                o_sel.alu_src = 1'b1;
                o_sel.alu_ctr = c_alu_add;
            end
            c_op_beq: begin
                o_iclass      = I_BEQ;
                o_sel.alu_ctr = c_alu_sub;
                o_sel.npc_sel = c_npc_br;
            end
            c_op_lui: begin
                o_iclass        = I_LUI;
                o_sel.reg_dst   = c_rd_rt;
                o_sel.memto_reg = c_m2r_lui;
            end
            c_op_jal: begin
                o_iclass        = I_JAL;
                o_sel.reg_dst   = RA_SEL;
                o_sel.memto_reg = c_m2r_pc;
                o_sel.npc_sel   = c_npc_j;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB) with
//            state-gated write enables. Define MC_CTRL_MEMWAIT_EN to hold MEM
//            until mem_ready; otherwise MEM always lasts one cycle.
//            A nop/unknown instruction always occupies 2 cycles (NOP_TO).
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [1:0] RA_SEL = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] nPC_sel,
    output logic       ExtOP,
    output logic [1:0] ALUctr,
    output logic [2:0] state,
    output logic       instr_done
);

    state_t  r_state;
    state_t  w_next;
    iclass_t w_iclass;
    sel_t    w_sel;
    logic    w_mem_done;
    logic    w_pcwr;
    logic    w_irwr;
    logic    w_regwr;
    logic    w_memwr;
    logic    w_done;

    mc_ctrl_dec #(
        .RA_SEL   (RA_SEL)
    ) u_dec (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_iclass (w_iclass),
        .o_sel    (w_sel)
    );

`ifdef MC_CTRL_MEMWAIT_EN
    assign w_mem_done = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_done         = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Illegal encodings fall through to the defaults: FETCH next, no enables.
    always_comb begin
        w_next  = S_FETCH;
        w_pcwr  = 1'b0;
        w_irwr  = 1'b0;
        w_regwr = 1'b0;
        w_memwr = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_pcwr = 1'b1;
                w_irwr = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_iclass)
                    I_JR: begin
                        w_pcwr = 1'b1;
                        w_done = 1'b1;
                    end
                    I_NOP:   w_done = 1'b1;
                    I_JAL:   w_next = S_WB;
                    default: w_next = S_EXE;
                endcase
            end
            S_EXE: begin
                case (w_iclass)
                    I_BEQ: begin
                        w_pcwr = zero;
                        w_done = 1'b1;
                    end
                    I_LW, I_SW:                   w_next = S_MEM;
                    I_ADDU, I_SUBU, I_ORI, I_LUI: w_next = S_WB;
                    default: ;
                endcase
            end
            S_MEM: begin
                w_memwr = (w_iclass == I_SW);
                if (!w_mem_done) begin
                    w_next = S_MEM;
                end else if (w_iclass == I_LW) begin
                    w_next = S_WB;
                end else begin
                    w_done = 1'b1;
                end
            end
            S_WB: begin
                w_regwr = 1'b1;
                w_done  = 1'b1;
                w_pcwr  = (w_iclass == I_JAL);
            end
            default: ;
        endcase
    end

    // Reset overrides everything visible so a mid-instruction reset writes nothing.
    assign PCWr       = ~reset & w_pcwr;
    assign IRWr       = ~reset & w_irwr;
    assign RegWrite   = ~reset & w_regwr;
    assign MemWrite   = ~reset & w_memwr;
    assign instr_done = ~reset & w_done;

    assign RegDst     = reset ? 2'b00 : w_sel.reg_dst;
    assign ALUSrc     = ~reset & w_sel.alu_src;
    assign MemtoReg   = reset ? 2'b00 : w_sel.memto_reg;
    assign ExtOP      = ~reset & w_sel.ext_op;
    assign ALUctr     = reset ? 2'b00 : w_sel.alu_ctr;
    assign nPC_sel    = (reset || (r_state == S_FETCH)) ? c_npc_pc4 : w_sel.npc_sel;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Self-checking bench for mc_ctrl: vector table, corner sequences
//            and randomized instruction stream against a path-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

`ifdef MC_CTRL_MEMWAIT_EN
    localparam bit MW = 1'b1;
`else
    localparam bit MW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWr, IRWr, ALUSrc, RegWrite, MemWrite, ExtOP, instr_done;
    logic [1:0] RegDst, MemtoReg, nPC_sel, ALUctr;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [1:0] rd;
        logic       src;
        logic [1:0] m2r;
        logic       ext;
        logic [1:0] alu;
        logic [1:0] npc;
    } vec_t;

    vec_t tbl[12];

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWr       (PCWr),
        .IRWr       (IRWr),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .nPC_sel    (nPC_sel),
        .ExtOP      (ExtOP),
        .ALUctr     (ALUctr),
        .state      (state),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {2'b00, act}, {2'b00, exp});
    endtask

    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        chk(nm, {1'b0, act}, {1'b0, exp});
    endtask

    function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic [1:0] rd, input logic src,
                                input logic [1:0] m2r, input logic ext, input logic [1:0] alu,
                                input logic [1:0] npc);
        vec_t v;
        v.name = n; v.op = op; v.fn = fn; v.z = z; v.rd = rd; v.src = src;
        v.m2r = m2r; v.ext = ext; v.alu = alu; v.npc = npc;
        return v;
    endfunction

    // Instruction class: 1 addu 2 subu 3 ori 4 lw 5 sw 6 beq 7 lui 8 jal 9 jr 0 nop
    function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h21:   return 1;
                    6'h23:   return 2;
                    6'h08:   return 9;
                    default: return 0;
                endcase
            end
            6'h0d:   return 3;
            6'h23:   return 4;
            6'h2b:   return 5;
            6'h04:   return 6;
            6'h0f:   return 7;
            6'h03:   return 8;
            default: return 0;
        endcase
    endfunction

    // Runs one instruction starting in its FETCH cycle (just after a rising edge).
    // w = cycles mem_ready stays low in MEM (only meaningful with the wait option).
    task automatic run_instr(input int vi, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int w);
        int p[$];
        int c  = cls(op, fn);
        int ws = MW ? w : 0;
        int mi = 0;
        p = {0, 1};
        case (c)
            0, 9: ;
            8:    p.push_back(4);
            6:    p.push_back(2);
            4: begin
                p.push_back(2);
                for (int i = 0; i <= ws; i++) p.push_back(3);
                p.push_back(4);
            end
            5: begin
                p.push_back(2);
                for (int i = 0; i <= ws; i++) p.push_back(3);
            end
            default: begin
                p.push_back(2);
                p.push_back(4);
            end
        endcase
        opcode = op;
        funct  = fn;
        for (int k = 0; k < p.size(); k++) begin
            int   s = p[k];
            logic e_pcwr;
            string tag;
            tag  = $sformatf("%s op=%0h fn=%0h cyc%0d", tbl[vi].name, op, fn, k);
            zero = (s == 2) ? z : 1'($urandom_range(0, 1));
            if (s == 3 && MW) begin
                mem_ready = (mi == ws);
                mi++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            e_pcwr = (s == 0) || (s == 1 && c == 9) || (s == 2 && c == 6 && z) || (s == 4 && c == 8);
            @(negedge clk);
            chk({tag, " state"}, state, 3'(s));
            chk1({tag, " PCWr"}, PCWr, e_pcwr);
            chk1({tag, " IRWr"}, IRWr, s == 0);
            chk1({tag, " RegWrite"}, RegWrite, s == 4);
            chk1({tag, " MemWrite"}, MemWrite, s == 3 && c == 5);
            chk1({tag, " instr_done"}, instr_done, k == p.size() - 1);
            chk2({tag, " nPC_sel"}, nPC_sel, (s == 0) ? 2'b00 : tbl[vi].npc);
            if (s != 0) begin
                chk2({tag, " RegDst"}, RegDst, tbl[vi].rd);
                chk1({tag, " ALUSrc"}, ALUSrc, tbl[vi].src);
                chk2({tag, " MemtoReg"}, MemtoReg, tbl[vi].m2r);
                chk1({tag, " ExtOP"}, ExtOP, tbl[vi].ext);
                chk2({tag, " ALUctr"}, ALUctr, tbl[vi].alu);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        tbl[0]  = mk("addu", 6'h00, 6'h21, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        tbl[1]  = mk("subu", 6'h00, 6'h23, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00);
        tbl[2]  = mk("ori",  6'h0d, 6'h00, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'b10, 2'b00);
        tbl[3]  = mk("lw",   6'h23, 6'h00, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00);
        tbl[4]  = mk("sw",   6'h2b, 6'h00, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
        tbl[5]  = mk("beq1", 6'h04, 6'h00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01);
        tbl[6]  = mk("beq0", 6'h04, 6'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01);
        tbl[7]  = mk("lui",  6'h0f, 6'h00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00);
        tbl[8]  = mk("jal",  6'h03, 6'h00, 1'b0, 2'b10, 1'b0, 2'b11, 1'b0, 2'b00, 2'b10);
        tbl[9]  = mk("jr",   6'h00, 6'h08, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11);
        tbl[10] = mk("nop",  6'h3f, 6'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        tbl[11] = mk("sll",  6'h00, 6'h00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);

        // Reset held for two edges with an opcode whose selects are all non-zero-ish.
        reset = 1'b1; opcode = 6'h03; funct = 6'h08; zero = 1'b1; mem_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("reset state", state, 3'd0);
            chk1("reset PCWr", PCWr, 1'b0);
            chk1("reset IRWr", IRWr, 1'b0);
            chk1("reset RegWrite", RegWrite, 1'b0);
            chk1("reset MemWrite", MemWrite, 1'b0);
            chk1("reset instr_done", instr_done, 1'b0);
            chk2("reset RegDst", RegDst, 2'b00);
            chk2("reset MemtoReg", MemtoReg, 2'b00);
            chk2("reset nPC_sel", nPC_sel, 2'b00);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Vector table, in order: includes beq taken/not-taken and jal followed by jr.
        for (int i = 0; i < 12; i++) run_instr(i, tbl[i].op, tbl[i].fn, tbl[i].z, 0);

        // Memory stalls (collapse to single-cycle MEM without the wait option).
        run_instr(4, 6'h2b, 6'h00, 1'b0, 3);
        run_instr(3, 6'h23, 6'h00, 1'b0, 2);

        // lw abandoned by a reset while in MEM: no WB may follow.
        hold = MW ? 2 : 0;
        opcode = 6'h23; funct = 6'h00;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            chk("abort pre state", state, 3'(k));
            @(posedge clk);
            #1;
        end
        for (int k = 0; k <= hold; k++) begin
            if (k == hold) reset = 1'b1;
            mem_ready = (k == hold);
            @(negedge clk);
            chk("abort MEM state", state, 3'd3);
            chk1("abort RegWrite", RegWrite, 1'b0);
            chk1("abort instr_done", instr_done, 1'b0);
            chk1("abort PCWr", PCWr, 1'b0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        run_instr(0, 6'h00, 6'h21, 1'b0, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            int         vi = $urandom_range(0, 11);
            logic [5:0] op = tbl[vi].op;
            logic [5:0] fn = tbl[vi].fn;
            logic       z  = tbl[vi].z;
            if (cls(op, fn) == 0) begin
                for (int t = 0; t < 100 && cls(op, fn) == 0 && op == tbl[vi].op; t++) begin
                    op = 6'($urandom_range(0, 63));
                    fn = 6'($urandom_range(0, 63));
                end
                for (int t = 0; t < 100 && cls(op, fn) != 0; t++) begin
                    op = 6'($urandom_range(0, 63));
                    fn = 6'($urandom_range(0, 63));
                end
                if (cls(op, fn) != 0) begin
                    op = 6'h3f;
                end
            end else if (op != 6'h00) begin
                fn = 6'($urandom_range(0, 63));
            end
            if (cls(op, fn) == 6) z = 1'($urandom_range(0, 1));
            run_instr(vi, op, fn, z, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
